icache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache between the datapath fetch port and the memory controller.
//  - Serves imemREN/imemaddr from the datapath.
//  - Returns ihit/imemload to the datapath.
//  - On a miss, fills one word per frame from the controller's instruction port (iREN/iaddr/iwait/iload).
//  - No write path; self-modifying code is not supported.

---
 rtl/icache_dm_pkg.sv | 12 +
 rtl/icache_dm_frames.sv | 33 +++
 rtl/icache_dm.sv | 61 ++++++
 tb/tb_icache_dm.sv | 139 +++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg: shared types for the direct-mapped instruction cache
package icache_dm_pkg;
  localparam int IC_FRAMES = 16;
  localparam int IC_IDX_W = $clog2(IC_FRAMES);
  localparam int IC_TAG_W = 30 - IC_IDX_W;
  typedef struct packed {
    logic [IC_TAG_W-1:0] tag;
    logic [IC_IDX_W-1:0] idx;
    logic [1:0]          bytoff;
  } icachef_t;
  typedef enum logic {IC_IDLE, IC_FETCH} icache_state_t;
endpackage

// File: rtl/icache_dm_frames.sv
// icache_dm_frames: valid/tag/data frame array, async read, sync write
module icache_dm_frames #(
  parameter int FRAMES = 16,
  parameter int IDX_W = $clog2(FRAMES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] ridx_i,
  output logic             rvalid_o,
  output logic [TAG_W-1:0] rtag_o,
  output logic [31:0]      rdat_o,
  input  logic             wen_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [TAG_W-1:0] wtag_i,
  input  logic [31:0]      wdat_i
);
  logic [FRAMES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [FRAMES];
  logic [31:0]       dat_q [FRAMES];
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) valid_q <= '0;
    else if (wen_i) valid_q[widx_i] <= 1'b1;
  // Tag and data carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge CLK)
    if (wen_i) begin
      tag_q[widx_i] <= wtag_i;
      dat_q[widx_i] <= wdat_i;
    end
  assign rvalid_o = valid_q[ridx_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rdat_o   = dat_q[ridx_i];
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with single-word miss fill
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int FRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);
  localparam int IDX_W = $clog2(FRAMES);
  localparam int TAG_W = 30 - IDX_W;
  icache_state_t    state_q;
  logic [31:2]      miss_addr_q;
  logic [31:0]      hit_cnt_q, miss_cnt_q;
  logic             rvalid, hit, wen;
  logic [TAG_W-1:0] rtag;
  logic [31:0]      rdat;
  logic             unused_bytoff;
  assign unused_bytoff = ^imemaddr[1:0];
  assign hit      = state_q == IC_IDLE && imemREN && rvalid && rtag == imemaddr[31:IDX_W+2];
  assign wen      = state_q == IC_FETCH && !iwait;
  assign ihit     = hit;
  assign imemload = hit ? rdat : '0;
  assign iREN     = state_q == IC_FETCH;
  assign iaddr    = iREN ? {miss_addr_q, 2'b00} : '0;
  icache_dm_frames #(.FRAMES(FRAMES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_frames (
    .CLK     (CLK),
    .nRST    (nRST),
    .ridx_i  (imemaddr[IDX_W+1:2]),
    .rvalid_o(rvalid),
    .rtag_o  (rtag),
    .rdat_o  (rdat),
    .wen_i   (wen),
    .widx_i  (miss_addr_q[IDX_W+1:2]),
    .wtag_i  (miss_addr_q[31:IDX_W+2]),
    .wdat_i  (iload)
  );
  // A started fill always runs to completion; only reset abandons it.
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      state_q     <= IC_IDLE;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else if (state_q == IC_IDLE) begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      else if (imemREN) begin
        state_q     <= IC_FETCH;
        miss_addr_q <= imemaddr[31:2];
        miss_cnt_q  <= miss_cnt_q + 32'd1;
      end
    end else if (!iwait) state_q <= IC_IDLE;
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed table plus randomized run against an address-level cache model
module tb_icache_dm;
  logic        CLK, nRST, imemREN, ihit, iREN, iwait;
  logic [31:0] imemaddr, imemload, iaddr, iload;
  int nchk = 0, nfail = 0;
  icache_dm dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
    .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2001_0005 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_1234);
  endfunction
  assign iload = iREN ? mem_of(iaddr) : 32'hDEAD_BEEF;
  // Model: each of 16 slots remembers the full word address it holds.
  bit          mf;
  logic [31:0] ma;
  bit          cv [16];
  logic [31:0] ca [16];
  int          mh, mm;
  logic        s_hit, s_iren, m_hit, m_iren;
  logic [31:0] s_load, s_iaddr, m_load, m_iaddr;
  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction
  task automatic model_reset();
    mf = 0; ma = 0; mh = 0; mm = 0;
    for (int i = 0; i < 16; i++) cv[i] = 0;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic cyc(input bit r, input logic [31:0] a, input bit w);
    logic [31:0] wa;
    imemREN = r; imemaddr = a; iwait = w;
    wa = a & ~32'd3;
    #3;
    m_hit   = !mf && r && cv[slot(wa)] && ca[slot(wa)] == wa;
    m_load  = m_hit ? mem_of(wa) : 32'd0;
    m_iren  = mf;
    m_iaddr = mf ? ma : 32'd0;
    s_hit = ihit; s_load = imemload; s_iren = iREN; s_iaddr = iaddr;
    @(posedge CLK);
    if (!mf) begin
      if (m_hit) mh++;
      else if (r) begin mf = 1; ma = wa; mm++; end
    end else if (!w) begin
      cv[slot(ma)] = 1; ca[slot(ma)] = ma; mf = 0;
    end
    #1;
  endtask
  typedef struct {
    bit r; logic [31:0] a; bit w;
    bit hit; logic [31:0] load; bit iren; logic [31:0] iaddr;
  } vec_t;
  vec_t tbl [20];
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl = '{
      '{1, 32'h40,  0, 0, 0, 0, 0},
      '{1, 32'h40,  0, 0, 0, 1, 32'h40},
      '{1, 32'h40,  0, 1, 32'h2001_0005, 0, 0},
      '{1, 32'h40,  0, 1, 32'h2001_0005, 0, 0},
      '{1, 32'h43,  0, 1, 32'h2001_0005, 0, 0},
      '{0, 32'h40,  0, 0, 0, 0, 0},
      '{1, 32'h440, 1, 0, 0, 0, 0},
      '{1, 32'h440, 1, 0, 0, 1, 32'h440},
      '{1, 32'h440, 1, 0, 0, 1, 32'h440},
      '{1, 32'h440, 1, 0, 0, 1, 32'h440},
      '{1, 32'h440, 0, 0, 0, 1, 32'h440},
      '{1, 32'h440, 0, 1, mem_of(32'h440), 0, 0},
      '{1, 32'h40,  0, 0, 0, 0, 0},
      '{1, 32'h40,  0, 0, 0, 1, 32'h40},
      '{1, 32'h80,  0, 0, 0, 0, 0},
      '{1, 32'h84,  0, 0, 0, 1, 32'h80},
      '{1, 32'h84,  0, 0, 0, 0, 0},
      '{1, 32'h84,  0, 0, 0, 1, 32'h84},
      '{1, 32'h80,  0, 1, mem_of(32'h80), 0, 0},
      '{1, 32'h84,  0, 1, mem_of(32'h84), 0, 0}
    };
    nRST = 0; imemREN = 0; imemaddr = 0; iwait = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
    #2;
    chk("rst_ihit", ihit, 0);
    chk("rst_iREN", iREN, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_imemload", imemload, 0);
    chk("rst_cnts", dut.hit_cnt_q | dut.miss_cnt_q, 0);
    @(posedge CLK); #1;
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].a, tbl[i].w);
      chk($sformatf("tbl%0d_ihit", i), s_hit, tbl[i].hit);
      chk($sformatf("tbl%0d_imemload", i), s_load, tbl[i].load);
      chk($sformatf("tbl%0d_iREN", i), s_iren, tbl[i].iren);
      chk($sformatf("tbl%0d_iaddr", i), s_iaddr, tbl[i].iaddr);
    end
    chk("tbl_hit_cnt", dut.hit_cnt_q, 6);
    chk("tbl_miss_cnt", dut.miss_cnt_q, 5);
    // Reset while a fill is stalled: iREN must drop without waiting for a clock.
    cyc(1, 32'h100, 1);
    cyc(1, 32'h100, 1);
    chk("mid_iREN_before", iREN, 1);
    nRST = 0;
    #1;
    chk("mid_iREN_async", iREN, 0);
    chk("mid_iaddr_async", iaddr, 0);
    chk("mid_valid_clear", dut.u_frames.valid_q, 0);
    model_reset();
    @(posedge CLK); #1 nRST = 1;
    cyc(1, 32'h84, 0);
    chk("mid_prior_hit_misses", s_hit, 0);
    cyc(1, 32'h84, 0);
    chk("mid_refetch_iaddr", s_iaddr, 32'h84);
    for (int k = 0; k < 400; k++) begin
      logic [31:0] ra;
      ra = {20'd0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 2'($urandom)};
      cyc(1'($urandom_range(0, 5) != 0), ra, 1'($urandom_range(0, 2) == 0));
      chk($sformatf("rnd%0d_ihit", k), s_hit, m_hit);
      chk($sformatf("rnd%0d_imemload", k), s_load, m_load);
      chk($sformatf("rnd%0d_iREN", k), s_iren, m_iren);
      chk($sformatf("rnd%0d_iaddr", k), s_iaddr, m_iaddr);
    end
    chk("rnd_hit_cnt", dut.hit_cnt_q, mh);
    chk("rnd_miss_cnt", dut.miss_cnt_q, mm);
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
